// File: rtl/io_stream_write_array_pkg.sv
// Shared definitions for the stream-to-array writer: FSM state encoding
// and default widths used when the parent does not override them.
package io_stream_write_array_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_EMIT  = 2'd2
   } wr_state_e;

   localparam int unsigned DEF_N = 32;
   localparam int unsigned DEF_A = 8;

endpackage

// File: rtl/io_stream_write_array.sv
// Drains a data stream into an array write port at ascending, wrapping
// addresses and announces each completed write on an address stream.
module io_stream_write_array
   import io_stream_write_array_pkg::*;
#(
   parameter int unsigned N    = DEF_N,
   parameter int unsigned A    = DEF_A,
   parameter int unsigned BASE = 0
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   input  logic [N-1:0] sIn,
   input  logic         sIn_valid,
   output logic         sIn_ready,
   output logic [A-1:0] sOut,
   output logic         sOut_valid,
   input  logic         sOut_ready,
   output logic [A-1:0] arr_addr,
   output logic [N-1:0] arr_di,
   output logic         arr_we,
   output logic         arr_valid,
   input  logic         arr_ready
);

   wr_state_e    state_q, state_d;
   logic [A-1:0] wr_ptr_q, wr_ptr_d;
   logic [N-1:0] data_q, data_d;
   logic [A-1:0] sout_q, sout_d;
   logic [A-1:0] arr_addr_q, arr_addr_d;
   logic         arr_valid_q, arr_valid_d;
   logic         sout_valid_q, sout_valid_d;
   logic         in_ready_q, in_ready_d;
   logic         sin_ready_c;
   logic         unused_out_ready;

   assign unused_out_ready = out_ready;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      data_d      = data_q;
      sout_d      = sout_q;
      arr_addr_d  = arr_addr_q;
      sin_ready_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            sin_ready_c = in_valid;
            if (sIn_valid && in_valid) begin
               data_d     = sIn;
               arr_addr_d = wr_ptr_q;
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (arr_ready) begin
               sout_d   = wr_ptr_q;
               wr_ptr_d = wr_ptr_q + A'(1);
               state_d  = ST_EMIT;
            end
         end
         ST_EMIT: begin
            // Bypass: a word taken alongside the sOut handshake skips IDLE.
            sin_ready_c = in_valid & sOut_ready;
            if (sOut_ready) begin
               if (sIn_valid && in_valid) begin
                  data_d     = sIn;
                  arr_addr_d = wr_ptr_q;
                  state_d    = ST_WRITE;
               end else begin
                  state_d    = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      arr_valid_d  = (state_d == ST_WRITE);
      sout_valid_d = (state_d == ST_EMIT);
      in_ready_d   = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= A'(BASE);
         data_q       <= '0;
         sout_q       <= '0;
         arr_addr_q   <= '0;
         arr_valid_q  <= 1'b0;
         sout_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         data_q       <= data_d;
         sout_q       <= sout_d;
         arr_addr_q   <= arr_addr_d;
         arr_valid_q  <= arr_valid_d;
         sout_valid_q <= sout_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   // sIn_ready is held low while reset is asserted even if in_valid is high.
   assign sIn_ready  = nrst & sin_ready_c;
   assign in_ready   = in_ready_q;
   assign out_valid  = in_ready_q & in_valid;
   assign sOut       = sout_q;
   assign sOut_valid = sout_valid_q;
   assign arr_addr   = arr_addr_q;
   assign arr_di     = data_q;
   assign arr_valid  = arr_valid_q;
   assign arr_we     = arr_valid_q;

endmodule

// File: tb/tb_io_stream_write_array.sv
// Bench for io_stream_write_array: cycle table for the handshake flags,
// scoreboard for array writes and emitted addresses, hand-written corner cases.
module tb_io_stream_write_array;

   localparam int unsigned N = 8;
   localparam int unsigned A = 4;

   logic         clk;
   logic         nrst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [N-1:0] sIn;
   logic         sIn_valid, sIn_ready;
   logic [A-1:0] sOut;
   logic         sOut_valid, sOut_ready;
   logic [A-1:0] arr_addr;
   logic [N-1:0] arr_di;
   logic         arr_we, arr_valid, arr_ready;

   io_stream_write_array #(.N(N), .A(A), .BASE(0)) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .sIn(sIn), .sIn_valid(sIn_valid), .sIn_ready(sIn_ready),
      .sOut(sOut), .sOut_valid(sOut_valid), .sOut_ready(sOut_ready),
      .arr_addr(arr_addr), .arr_di(arr_di), .arr_we(arr_we),
      .arr_valid(arr_valid), .arr_ready(arr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expected writes {addr,data} and expected emitted addresses.
   logic [A+N-1:0] exp_wr[$];
   logic [A-1:0]   exp_out[$];
   logic [A-1:0]   mptr;
   logic [N-1:0]   mem[16];
   int             cyc = 0;
   int             last_cyc;
   bit             have_last;
   bit             gap_en = 0;

   always @(posedge clk) cyc++;

   always @(negedge nrst) begin
      exp_wr.delete();
      exp_out.delete();
      mptr = '0;
   end

   always @(negedge clk) begin
      if (nrst) begin
         if (sIn_valid && sIn_ready) begin
            exp_wr.push_back({mptr, sIn});
            exp_out.push_back(mptr);
            mptr = mptr + 1'b1;
         end
         if (arr_valid && arr_ready) begin
            chk("we_eq_valid", 32'(arr_we), 32'd1);
            if (exp_wr.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
               logic [A+N-1:0] e;
               e = exp_wr.pop_front();
               chk("arr_addr", 32'(arr_addr), 32'(e[A+N-1:N]));
               chk("arr_di", 32'(arr_di), 32'(e[N-1:0]));
            end
            mem[arr_addr] = arr_di;
         end
         if (sOut_valid && sOut_ready) begin
            if (exp_out.size() == 0) chk("unexpected_sout", 32'd1, 32'd0);
            else chk("sout", 32'(sOut), 32'(exp_out.pop_front()));
            if (gap_en && have_last) chk("sout_gap", 32'(cyc - last_cyc), 32'd2);
            last_cyc  = cyc;
            have_last = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_words(input int start, input int n);
      for (int i = 0; i < n; i++) begin
         int  waitc;
         bit  got;
         waitc = 0;
         got   = 1'b0;
         sIn       = N'(start + i);
         sIn_valid = 1'b1;
         while (!got && waitc < 50) begin
            @(negedge clk);
            got = sIn_ready;
            step();
            waitc++;
         end
         if (!got) chk("accept_timeout", 32'd0, 32'd1);
      end
      sIn_valid = 1'b0;
   endtask

   task automatic drain();
      int waitc;
      waitc = 0;
      while ((exp_out.size() != 0 || exp_wr.size() != 0) && waitc < 100) begin
         step();
         waitc++;
      end
      chk("drain_timeout", 32'(exp_out.size() + exp_wr.size()), 32'd0);
   endtask

   typedef struct {
      logic         iv, sv, ar, sr;
      logic [N-1:0] d;
      logic         e_in_ready, e_sin_ready, e_arr_valid, e_sout_valid, e_out_valid;
   } vec_t;

   vec_t tbl[7];

   initial begin
      //            iv    sv    ar    sr    d      inr   sinr  arv   sov   outv
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      in_valid = 1'b1; out_ready = 1'b1; sIn = '0; sIn_valid = 1'b0;
      sOut_ready = 1'b0; arr_ready = 1'b0;
      mptr = '0;
      nrst = 1'b1;
      #1 nrst = 1'b0;
      #2;
      chk("rst_in_ready",   32'(in_ready),   32'd1);
      chk("rst_sin_ready",  32'(sIn_ready),  32'd0);
      chk("rst_arr_valid",  32'(arr_valid),  32'd0);
      chk("rst_arr_we",     32'(arr_we),     32'd0);
      chk("rst_sout_valid", 32'(sOut_valid), 32'd0);
      chk("rst_sout",       32'(sOut),       32'd0);
      chk("rst_arr_addr",   32'(arr_addr),   32'd0);
      chk("rst_arr_di",     32'(arr_di),     32'd0);
      step(); step();
      nrst = 1'b1;

      // Single word walked through the FSM one cycle at a time.
      for (int i = 0; i < 7; i++) begin
         step();
         in_valid = tbl[i].iv; sIn_valid = tbl[i].sv; sIn = tbl[i].d;
         arr_ready = tbl[i].ar; sOut_ready = tbl[i].sr;
         #3;
         chk($sformatf("tbl%0d_in_ready", i),   32'(in_ready),   32'(tbl[i].e_in_ready));
         chk($sformatf("tbl%0d_sin_ready", i),  32'(sIn_ready),  32'(tbl[i].e_sin_ready));
         chk($sformatf("tbl%0d_arr_valid", i),  32'(arr_valid),  32'(tbl[i].e_arr_valid));
         chk($sformatf("tbl%0d_sout_valid", i), 32'(sOut_valid), 32'(tbl[i].e_sout_valid));
         chk($sformatf("tbl%0d_out_valid", i),  32'(out_valid),  32'(tbl[i].e_out_valid));
      end
      step();
      sIn_valid = 1'b0;
      drain();

      // Back-to-back stream 0..19 with zero-wait array: wraps 15 -> 0.
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      in_valid = 1'b1; arr_ready = 1'b1; sOut_ready = 1'b1;
      have_last = 1'b0; gap_en = 1'b1;
      send_words(0, 20);
      drain();
      gap_en = 1'b0;
      for (int i = 0; i < 16; i++)
         chk($sformatf("mem%0d", i), 32'(mem[i]), (i < 4) ? 32'(i + 16) : 32'(i));

      // Array stalls 5 cycles during the write of 7 (address 4).
      arr_ready = 1'b0;
      send_words(7, 1);
      for (int k = 0; k < 5; k++) begin
         #3;
         chk("stall_arr_valid",  32'(arr_valid),  32'd1);
         chk("stall_arr_addr",   32'(arr_addr),   32'd4);
         chk("stall_arr_di",     32'(arr_di),     32'd7);
         chk("stall_sout_valid", 32'(sOut_valid), 32'd0);
         step();
      end
      arr_ready = 1'b1;
      #3 chk("stall_sout_before", 32'(sOut_valid), 32'd0);
      step();
      #1 chk("stall_sout_after", 32'(sOut_valid), 32'd1);
      chk("stall_sout_addr", 32'(sOut), 32'd4);
      drain();

      // Consumer stalls 4 cycles in EMIT (address 5), then bypass resumes.
      sOut_ready = 1'b0;
      send_words(9, 1);
      step();
      sIn = 8'd10; sIn_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #3;
         chk("emit_sout_valid", 32'(sOut_valid), 32'd1);
         chk("emit_sout",       32'(sOut),       32'd5);
         chk("emit_sin_ready",  32'(sIn_ready),  32'd0);
         chk("emit_arr_valid",  32'(arr_valid),  32'd0);
         step();
      end
      sOut_ready = 1'b1;
      send_words(10, 1);
      drain();
      chk("mem5", 32'(mem[5]), 32'd9);
      chk("mem6", 32'(mem[6]), 32'd10);

      // Reset during WRITE: word dropped, next word lands at BASE.
      arr_ready = 1'b0;
      send_words(8'h33, 1);
      #1 nrst = 1'b0;
      #1;
      chk("midrst_arr_valid", 32'(arr_valid), 32'd0);
      chk("midrst_in_ready",  32'(in_ready),  32'd1);
      chk("midrst_arr_addr",  32'(arr_addr),  32'd0);
      chk("midrst_sin_ready", 32'(sIn_ready), 32'd0);
      step();
      nrst = 1'b1; arr_ready = 1'b1;
      send_words(8'h44, 1);
      drain();
      chk("midrst_mem0", 32'(mem[0]), 32'h44);
      chk("midrst_mem7", 32'(mem[7]), 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
